// File: rtl/multipler_pkg.sv
// Shared types and sizing for the block-wise multiplier's partial-product accumulator.
package multipler_pkg;

    localparam int DATA_LENGTH  = 64;
    localparam int BLOCK_LENGTH = 16;
    localparam int NUM_BLOCKS   = DATA_LENGTH / BLOCK_LENGTH;
    localparam int NUM_MULS     = NUM_BLOCKS * NUM_BLOCKS;
    localparam int IDX_W        = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int CNT_W        = $clog2(NUM_MULS) + 2;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        FINISH
    } state_t;

    typedef logic [CNT_W-1:0]          counter_t;
    typedef logic [IDX_W-1:0]          idx_t;
    typedef logic [2*BLOCK_LENGTH-1:0] pp_t;
    typedef logic [2*DATA_LENGTH-1:0]  wide_t;

endpackage

// File: rtl/pp_accumulator_if.sv
// Partial-product input stream and result output stream of the accumulator.
interface pp_accumulator_if;
    import multipler_pkg::*;

    logic  pp_valid;
    logic  pp_ready;
    pp_t   pp_data;
    idx_t  pp_idx_a;
    idx_t  pp_idx_b;
    logic  result_valid;
    logic  result_ready;
    wide_t result;

    // The accumulator side: sinks partial products, sources the result.
    modport slave (
        input  pp_valid, pp_data, pp_idx_a, pp_idx_b, result_ready,
        output pp_ready, result_valid, result
    );

    modport master (
        output pp_valid, pp_data, pp_idx_a, pp_idx_b, result_ready,
        input  pp_ready, result_valid, result
    );

endinterface

// File: rtl/pp_align.sv
// Places a partial product a_blk[i]*b_blk[j] at bit offset (i+j)*BLOCK_LENGTH of the wide product.
module pp_align
    import multipler_pkg::*;
(
    input  pp_t   pp_i,
    input  idx_t  idx_a_i,
    input  idx_t  idx_b_i,
    output wide_t term_o
);

    logic [IDX_W:0] blk_sum;

    always_comb begin
        blk_sum = {1'b0, idx_a_i} + {1'b0, idx_b_i};
        term_o  = wide_t'(pp_i) << (int'(blk_sum) * BLOCK_LENGTH);
    end

endmodule

// File: rtl/pp_accumulator.sv
// Accumulates NUM_MULS shifted partial products into the full product; result on valid/ready.
// Define PP_INDEX_CHECK_EN to flag duplicate (i,j) partial products on err_o.
module pp_accumulator
    import multipler_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    pp_accumulator_if.slave   bus,
    output logic              busy_o,
    output logic              err_o
);

    state_t   state_q, state_d;
    wide_t    acc_q, acc_d;
    counter_t cnt_q, cnt_d;
    wide_t    term;
    logic     pp_hs;
    logic     start_hs;

    pp_align u_align (
        .pp_i    (bus.pp_data),
        .idx_a_i (bus.pp_idx_a),
        .idx_b_i (bus.pp_idx_b),
        .term_o  (term)
    );

    assign pp_hs    = (state_q == COMPUTE) && bus.pp_valid;
    assign start_hs = (state_q == IDLE) && start_i;
    assign busy_o   = (state_q != IDLE);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d          = state_q;
        acc_d            = acc_q;
        cnt_d            = cnt_q;
        bus.pp_ready     = 1'b0;
        bus.result_valid = 1'b0;
        bus.result       = '0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                bus.pp_ready = 1'b1;
                if (pp_hs) begin
                    acc_d = acc_q + term;
                    cnt_d = cnt_q + counter_t'(1);
                    if (cnt_q == counter_t'(NUM_MULS - 1)) state_d = FINISH;
                end
            end
            FINISH: begin
                bus.result_valid = 1'b1;
                bus.result       = acc_q;
                if (bus.result_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PP_INDEX_CHECK_EN
    localparam int MAP_W = (NUM_MULS > 1) ? $clog2(NUM_MULS) : 1;

    logic [NUM_MULS-1:0] seen_q, seen_d;
    logic                err_q, err_d;
    logic [MAP_W-1:0]    map_idx;

    assign map_idx = MAP_W'(bus.pp_idx_a) * MAP_W'(NUM_BLOCKS) + MAP_W'(bus.pp_idx_b);

    // Duplicates are still accumulated; the flag is purely informational and sticky.
    always_comb begin
        seen_d = seen_q;
        err_d  = err_q;
        if (start_hs) begin
            seen_d = '0;
            err_d  = 1'b0;
        end else if (pp_hs) begin
            if (seen_q[map_idx]) err_d = 1'b1;
            seen_d[map_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            seen_q <= '0;
            err_q  <= 1'b0;
        end else begin
            seen_q <= seen_d;
            err_q  <= err_d;
        end
    end

    assign err_o = err_q;
`else
    logic unused_start_hs;
    assign unused_start_hs = start_hs;
    assign err_o           = 1'b0;
`endif

endmodule

// File: tb/tb_pp_accumulator.sv
// Self-checking bench for pp_accumulator: vector table plus hand-written corner sequences.
module tb_pp_accumulator;
    import multipler_pkg::*;

    typedef logic [31:0] pp_arr_t [16];
    typedef int          order_t  [16];

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        int          order;
        bit          gap;
        int          hold;
        wide_t       exp;
    } vec_t;

    logic clk_i;
    logic rst_i;
    logic start_i;
    logic busy_o;
    logic err_o;

    pp_accumulator_if bus ();

    pp_accumulator dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .bus     (bus.slave),
        .busy_o  (busy_o),
        .err_o   (err_o)
    );

    int    n_checks = 0;
    int    n_pass   = 0;
    wide_t sb_q[$];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input wide_t act, input wide_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    endtask

    // Scoreboard: compare whenever the DUT hands over a result.
    always @(negedge clk_i) begin
        if (!rst_i && bus.result_valid && bus.result_ready) begin
            check("sb_expected_pending", wide_t'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) check("result", bus.result, sb_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    function automatic pp_arr_t make_pps(input logic [63:0] a, input logic [63:0] b);
        pp_arr_t r;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                r[i*4+j] = 32'(a[16*i +: 16]) * 32'(b[16*j +: 16]);
        return r;
    endfunction

    function automatic order_t make_order(input int mode);
        order_t o;
        for (int k = 0; k < 16; k++) begin
            case (mode)
                1:       o[k] = 15 - k;
                2:       o[k] = (k * 5 + 3) % 16;
                default: o[k] = k;
            endcase
        end
        return o;
    endfunction

    function automatic wide_t model_sum(input pp_arr_t pps, input order_t ord);
        wide_t s = '0;
        for (int k = 0; k < 16; k++)
            s += wide_t'(pps[ord[k]]) << (16 * (ord[k] / 4 + ord[k] % 4));
        return s;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic run_stream(input string name, input pp_arr_t pps, input order_t ord,
                              input bit gap, input int hold, input wide_t exp);
        bit seen [16];
        bit dup;
        bit exp_err;
        dup = 1'b0;
        for (int k = 0; k < 16; k++) seen[k] = 1'b0;
        pulse_start();
        check({name, "_busy_after_start"}, wide_t'(busy_o), 1);
        check({name, "_err_after_start"}, wide_t'(err_o), 0);
        sb_q.push_back(exp);
        for (int k = 0; k < 16; k++) begin
            if (gap) begin
                bus.pp_valid = 1'b0;
                tick();
            end
            bus.pp_valid = 1'b1;
            bus.pp_data  = pps[ord[k]];
            bus.pp_idx_a = idx_t'(ord[k] / 4);
            bus.pp_idx_b = idx_t'(ord[k] % 4);
            if (k == 0) check({name, "_pp_ready"}, wide_t'(bus.pp_ready), 1);
            tick();
            if (seen[ord[k]]) dup = 1'b1;
            seen[ord[k]] = 1'b1;
`ifdef PP_INDEX_CHECK_EN
            exp_err = dup;
`else
            exp_err = 1'b0;
`endif
            check({name, "_err"}, wide_t'(err_o), wide_t'(exp_err));
            if (k == 14) check({name, "_no_early_valid"}, wide_t'(bus.result_valid), 0);
        end
        bus.pp_valid = 1'b0;
        check({name, "_valid_latency"}, wide_t'(bus.result_valid), 1);
        check({name, "_pp_ready_finish"}, wide_t'(bus.pp_ready), 0);
        for (int h = 0; h < hold; h++) begin
            start_i = (h == 1);
            tick();
            start_i = 1'b0;
            check({name, "_bp_result_stable"}, bus.result, exp);
            check({name, "_bp_valid_held"}, wide_t'(bus.result_valid), 1);
            check({name, "_bp_pp_ready"}, wide_t'(bus.pp_ready), 0);
        end
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
        check({name, "_idle_after_take"}, wide_t'(busy_o), 0);
        check({name, "_valid_dropped"}, wide_t'(bus.result_valid), 0);
        check({name, "_result_zero_idle"}, bus.result, 0);
        check({name, "_err_sticky"}, wide_t'(err_o), wide_t'(exp_err));
    endtask

    vec_t    vecs [4];
    pp_arr_t pps;
    order_t  ord;
    wide_t   exp_w;

    initial begin
        vecs[0] = '{"ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, 0,
                    128'hFFFFFFFFFFFFFFFE0000000000000001};
        vecs[1] = '{"gap_rev", 64'h0001_0002_0003_0004, 64'h5, 1, 1'b1, 0,
                    128'h0005000A000F0014};
        vecs[2] = '{"mixed", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 2, 1'b0, 0,
                    128'(64'h1234_5678_9ABC_DEF0) * 128'(64'h0FED_CBA9_8765_4321)};
        vecs[3] = '{"backpressure", 64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_FEDC_BA98, 0, 1'b0, 5,
                    128'(64'hDEAD_BEEF_0123_4567) * 128'(64'h89AB_CDEF_FEDC_BA98)};

        rst_i            = 1'b1;
        start_i          = 1'b0;
        bus.pp_valid     = 1'b0;
        bus.pp_data      = '0;
        bus.pp_idx_a     = '0;
        bus.pp_idx_b     = '0;
        bus.result_ready = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        check("reset_busy", wide_t'(busy_o), 0);
        check("reset_pp_ready", wide_t'(bus.pp_ready), 0);
        check("reset_valid", wide_t'(bus.result_valid), 0);
        check("reset_result", bus.result, 0);
        check("reset_err", wide_t'(err_o), 0);

        for (int v = 0; v < 4; v++)
            run_stream(vecs[v].name, make_pps(vecs[v].a, vecs[v].b), make_order(vecs[v].order),
                       vecs[v].gap, vecs[v].hold, vecs[v].exp);

        // Single term at the top-most shift position.
        for (int k = 0; k < 16; k++) pps[k] = 32'h0;
        pps[15] = 32'h1;
        run_stream("single_term", pps, make_order(0), 1'b0, 0,
                   128'h0000_0001_0000_0000_0000_0000_0000_0000);

        // Reset after 7 handshakes discards the run.
        pps = make_pps(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        pulse_start();
        for (int k = 0; k < 7; k++) begin
            bus.pp_valid = 1'b1;
            bus.pp_data  = pps[k];
            bus.pp_idx_a = idx_t'(k / 4);
            bus.pp_idx_b = idx_t'(k % 4);
            tick();
        end
        rst_i        = 1'b1;
        bus.pp_valid = 1'b0;
        tick();
        check("midrst_busy", wide_t'(busy_o), 0);
        check("midrst_pp_ready", wide_t'(bus.pp_ready), 0);
        check("midrst_valid", wide_t'(bus.result_valid), 0);
        check("midrst_result", bus.result, 0);
        check("midrst_err", wide_t'(err_o), 0);
        rst_i = 1'b0;
        tick();
        run_stream("restart", make_pps(64'h3, 64'h5), make_order(2), 1'b0, 0, 128'd15);

        // Duplicate (1,2) replaces (3,3); the product is still accumulated.
        pps = make_pps(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888);
        ord = make_order(0);
        ord[15] = 6;
        exp_w = model_sum(pps, ord);
        run_stream("duplicate", pps, ord, 1'b0, 0, exp_w);
        run_stream("after_dup", make_pps(64'h7, 64'h9), make_order(1), 1'b0, 0, 128'd63);

        tick();
        check("sb_drained", wide_t'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
